obf_seq_ctrl: RTL and testbench



---
 rtl/obf_seq_ctrl_pkg.sv | 22 ++
 rtl/obf_seq_ctrl_if.sv | 47 ++++
 rtl/obf_seq_perf.sv | 29 ++
 rtl/obf_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_obf_seq_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obf_seq_ctrl_pkg.sv
// Shared constants for the obfuscation LUT sequencer.
// Widths and type codes of the substitution LUT.
package obf_seq_ctrl_pkg;

    localparam int OBF_IGU_WIDTH     = 8;
    localparam int OBF_PPC_WIDTH     = 3;
    localparam int OBF_KEY_WIDTH     = 8;
    localparam int OBF_LUT_OUT_WIDTH = 16;

    // Type field occupies the top bits of every LUT entry.
    localparam int OBF_TYPE_W = 3;

    localparam logic [OBF_TYPE_W-1:0] OBF_INSN_TYPE_N = 3'd0;
    localparam logic [OBF_TYPE_W-1:0] OBF_INSN_TYPE_I = 3'd1;
    localparam logic [OBF_TYPE_W-1:0] OBF_INSN_TYPE_A = 3'd2;

    // True when a type field marks a terminator entry.
    function automatic logic obf_is_term(input logic [OBF_TYPE_W-1:0] t);
        return t == OBF_INSN_TYPE_N;
    endfunction

endpackage

// File: rtl/obf_seq_ctrl_if.sv
// Fetch-side, LUT and decode-side bundle of the LUT sequencer.
// slave = sequencer view, master = parent/environment view.
interface obf_seq_ctrl_if
    import obf_seq_ctrl_pkg::*;
#(
    parameter int IGU_W = OBF_IGU_WIDTH,
    parameter int PPC_W = OBF_PPC_WIDTH,
    parameter int KEY_W = OBF_KEY_WIDTH,
    parameter int LUT_W = OBF_LUT_OUT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_insn;
    logic [IGU_W-1:0] in_index;
    logic [KEY_W-1:0] in_key;

    logic [IGU_W-1:0] lut_index;
    logic [PPC_W-1:0] lut_ppc;
    logic [KEY_W-1:0] lut_key;
    logic [LUT_W-1:0] lut_sub;
    logic [LUT_W-1:0] lut_imm;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_insn;
    logic [LUT_W-1:0] out_sub;
    logic             out_first;
    logic             out_last;

    modport slave (
        input  in_valid, in_insn, in_index, in_key,
        input  lut_sub, lut_imm, out_ready,
        output in_ready, lut_index, lut_ppc, lut_key,
        output out_valid, out_insn, out_sub,
        output out_first, out_last
    );

    modport master (
        output in_valid, in_insn, in_index, in_key,
        output lut_sub, lut_imm, out_ready,
        input  in_ready, lut_index, lut_ppc, lut_key,
        input  out_valid, out_insn, out_sub,
        input  out_first, out_last
    );

endinterface

// File: rtl/obf_seq_perf.sv
// Input/output handshake counters of the LUT sequencer.
// Both wrap modulo 2^32.
module obf_seq_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_insn_inc,
    input  logic        i_emit_inc,
    output logic [31:0] o_insn_cnt,
    output logic [31:0] o_emit_cnt
);

    logic [31:0] r_insn_cnt;
    logic [31:0] r_emit_cnt;

    // Count accepted instructions and emitted entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insn_cnt <= '0;
            r_emit_cnt <= '0;
        end else begin
            if (i_insn_inc) r_insn_cnt <= r_insn_cnt + 32'd1;
            if (i_emit_inc) r_emit_cnt <= r_emit_cnt + 32'd1;
        end
    end

    assign o_insn_cnt = r_insn_cnt;
    assign o_emit_cnt = r_emit_cnt;

endmodule

// File: rtl/obf_seq_ctrl.sv
// Sequencer walking the substitution LUT, one entry per handshake.
// Optional counters enabled by macro OBF_SEQ_PERF_EN.
module obf_seq_ctrl
    import obf_seq_ctrl_pkg::*;
#(
    parameter int IGU_W = OBF_IGU_WIDTH,
    parameter int PPC_W = OBF_PPC_WIDTH,
    parameter int KEY_W = OBF_KEY_WIDTH,
    parameter int LUT_W = OBF_LUT_OUT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    obf_seq_ctrl_if.slave bus,
    output logic         busy,
    output logic         err_overrun,
    output logic [31:0]  perf_insn_cnt,
    output logic [31:0]  perf_emit_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [PPC_W-1:0] PPC_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_insn;
    logic [IGU_W-1:0] r_index;
    logic [KEY_W-1:0] r_key;
    logic [PPC_W-1:0] r_ppc;
    logic             r_err;
    // One-cycle return-to-IDLE slot after a sequence ends.
    logic             r_retire;

    logic w_emit;
    logic w_in_ready;
    logic w_in_fire;
    logic w_out_fire;
    logic w_first;
    logic w_last;
    logic w_sub_term;
    logic w_imm_term;
    logic w_ppc_max;
    logic w_overrun;

    assign w_emit     = (r_state == S_EMIT);
    assign w_sub_term = obf_is_term(bus.lut_sub[LUT_W-1 -: OBF_TYPE_W]);
    assign w_imm_term = obf_is_term(bus.lut_imm[LUT_W-1 -: OBF_TYPE_W]);
    assign w_ppc_max  = (r_ppc == PPC_MAX);
    assign w_first    = (r_ppc == '0);

    // Passthrough: a terminator at position 0 is itself the last entry.
    assign w_last = w_imm_term || w_ppc_max || (w_first && w_sub_term);

    assign w_in_ready = (r_state == S_IDLE) && !flush && !r_retire;
    assign w_in_fire  = w_in_ready && bus.in_valid;
    assign w_out_fire = w_emit && bus.out_ready && !flush;

    // Ran out of positions without the next entry terminating.
    assign w_overrun = w_out_fire && w_ppc_max && !w_imm_term;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = w_in_ready;
        bus.out_valid = 1'b0;
        bus.out_first = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_sub   = bus.lut_sub;
        unique case (r_state)
            S_IDLE: begin
                if (w_in_fire) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                bus.out_valid = 1'b1;
                bus.out_first = w_first;
                bus.out_last  = w_last;
                if (flush)
                    w_state_nxt = S_IDLE;
                else if (w_out_fire && w_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the instruction context and step the LUT position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insn   <= '0;
            r_index  <= '0;
            r_key    <= '0;
            r_ppc    <= '0;
            r_retire <= 1'b0;
        end else begin
            r_retire <= w_out_fire && w_last;
            if (w_in_fire) begin
                r_insn  <= bus.in_insn;
                r_index <= bus.in_index;
                r_key   <= bus.in_key;
                r_ppc   <= '0;
            end else if (w_emit && flush) begin
                r_ppc <= '0;
            end else if (w_out_fire && !w_last) begin
                r_ppc <= r_ppc + PPC_W'(1);
            end
        end
    end

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_err <= 1'b0;
        else if (w_overrun) r_err <= 1'b1;
    end

    assign bus.lut_index = r_index;
    assign bus.lut_ppc   = r_ppc;
    assign bus.lut_key   = r_key;
    assign bus.out_insn  = r_insn;
    assign busy          = (r_state != S_IDLE);
    assign err_overrun   = r_err;

`ifdef OBF_SEQ_PERF_EN
    obf_seq_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .i_insn_inc (w_in_fire),
        .i_emit_inc (w_out_fire),
        .o_insn_cnt (perf_insn_cnt),
        .o_emit_cnt (perf_emit_cnt)
    );
`else
    assign perf_insn_cnt = '0;
    assign perf_emit_cnt = '0;
`endif

endmodule

// File: tb/tb_obf_seq_ctrl.sv
// Directed bench for obf_seq_ctrl with a small behavioural LUT.
// Counter expectations follow macro OBF_SEQ_PERF_EN.
module tb_obf_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        busy;
    logic        err_overrun;
    logic [31:0] perf_insn_cnt;
    logic [31:0] perf_emit_cnt;

    int n_vec = 0;
    int n_err = 0;

`ifdef OBF_SEQ_PERF_EN
    localparam int PERF_EXP = 10;
`else
    localparam int PERF_EXP = 0;
`endif

    obf_seq_ctrl_if bus ();

    obf_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .bus           (bus),
        .busy          (busy),
        .err_overrun   (err_overrun),
        .perf_insn_cnt (perf_insn_cnt),
        .perf_emit_cnt (perf_emit_cnt)
    );

    always #5 clk = ~clk;

    // Bench LUT: 64 -> three I entries then N; 99 -> all A; 5 -> N.
    function automatic logic [15:0] lut_f(input logic [7:0] idx,
                                          input int pos,
                                          input logic [7:0] key);
        logic [12:0] k;
        k = {5'b0, key};
        if (idx == 8'd64) begin
            if (pos < 3) return {3'd1, 13'(32'h100 + pos + 1) ^ k};
            return 16'h0000;
        end
        if (idx == 8'd99) return {3'd2, 13'(32'h200 + pos) ^ k};
        if (idx == 8'd5)  return {3'd0, 13'h005 ^ k};
        return 16'h0000;
    endfunction

    always_comb begin
        bus.lut_sub = lut_f(bus.lut_index, int'(bus.lut_ppc), bus.lut_key);
        bus.lut_imm = lut_f(bus.lut_index, int'(bus.lut_ppc) + 1, bus.lut_key);
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic start(input logic [31:0] insn, input logic [7:0] idx,
                         input logic [7:0] key);
        bus.in_valid = 1'b1;
        bus.in_insn  = insn;
        bus.in_index = idx;
        bus.in_key   = key;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_insn = '0;
        bus.in_index = '0;
        bus.in_key = '0;
        #12;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready);
        end
        n_vec++;
        if ({bus.out_valid, bus.out_first, bus.out_last} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_out_flags got %b exp 000",
                     {bus.out_valid, bus.out_first, bus.out_last});
        end
        n_vec++;
        if ({bus.lut_index, bus.lut_ppc, bus.lut_key} !== 19'd0) begin
            n_err++;
            $display("FAIL rst_lut got %h exp 0",
                     {bus.lut_index, bus.lut_ppc, bus.lut_key});
        end
        n_vec++;
        if (bus.out_insn !== 32'd0) begin
            n_err++; $display("FAIL rst_out_insn got %h exp 0", bus.out_insn);
        end
        n_vec++;
        if ({busy, err_overrun} !== 2'b00) begin
            n_err++; $display("FAIL rst_busy_err got %b exp 00", {busy, err_overrun});
        end
        n_vec++;
        if ({perf_insn_cnt, perf_emit_cnt} !== 64'd0) begin
            n_err++;
            $display("FAIL rst_perf got %0d/%0d exp 0/0", perf_insn_cnt, perf_emit_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_seq3;
        logic [15:0] exp_sub [3];
        exp_sub = '{16'h213D, 16'h213E, 16'h213F};
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_insn = 32'hDEADBEEF;
        bus.in_index = 8'd64;
        bus.in_key = 8'h3C;
        @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL s3_ready_idle got %b exp 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.out_valid, bus.out_first, bus.out_last, bus.lut_ppc,
                 bus.out_sub} !== {1'b1, k == 0, k == 2, 3'(k), exp_sub[k]}) begin
                n_err++;
                $display("FAIL s3_emit%0d got v%b f%b l%b p%0d s%h exp s%h", k,
                         bus.out_valid, bus.out_first, bus.out_last,
                         bus.lut_ppc, bus.out_sub, exp_sub[k]);
            end
            n_vec++;
            if ({bus.in_ready, busy, bus.out_insn} !== {2'b01, 32'hDEADBEEF}) begin
                n_err++;
                $display("FAIL s3_ctx%0d got r%b b%b i%h", k, bus.in_ready,
                         busy, bus.out_insn);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.in_ready, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL s3_retire got v%b r%b b%b exp 000",
                     bus.out_valid, bus.in_ready, busy);
        end
        @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL s3_ready_back got %b exp 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough;
        bus.out_ready = 1'b1;
        start(32'h12345678, 8'd5, 8'hA5);
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.out_first, bus.out_last, bus.out_sub}
            !== {3'b111, 16'h00A0}) begin
            n_err++;
            $display("FAIL pt_emit got v%b f%b l%b s%h exp 111 00a0",
                     bus.out_valid, bus.out_first, bus.out_last, bus.out_sub);
        end
        n_vec++;
        if (bus.out_insn !== 32'h12345678) begin
            n_err++; $display("FAIL pt_insn got %h exp 12345678", bus.out_insn);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL pt_retire got v%b r%b exp 00", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL pt_ready_back got %b exp 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        bus.out_ready = 1'b1;
        start(32'hCAFEF00D, 8'd64, 8'h00);
        @(negedge clk);
        n_vec++;
        if ({bus.out_first, bus.lut_ppc, bus.out_sub} !== {1'b1, 3'd0, 16'h2101}) begin
            n_err++;
            $display("FAIL st_ppc0 got f%b p%0d s%h exp 1 0 2101",
                     bus.out_first, bus.lut_ppc, bus.out_sub);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            n_vec++;
            if ({bus.out_valid, bus.out_first, bus.out_last, bus.lut_ppc,
                 bus.out_sub} !== {3'b100, 3'd1, 16'h2102}) begin
                n_err++;
                $display("FAIL st_hold%0d got v%b f%b l%b p%0d s%h exp 100 1 2102",
                         c, bus.out_valid, bus.out_first, bus.out_last,
                         bus.lut_ppc, bus.out_sub);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({bus.out_last, bus.lut_ppc, bus.out_sub} !== {1'b1, 3'd2, 16'h2103}) begin
            n_err++;
            $display("FAIL st_ppc2 got l%b p%0d s%h exp 1 2 2103",
                     bus.out_last, bus.lut_ppc, bus.out_sub);
        end
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL st_done got %b exp 0", bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        bus.out_ready = 1'b1;
        start(32'h11112222, 8'd64, 8'h00);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, bus.lut_ppc, bus.in_ready} !== {1'b1, 3'd1, 1'b0}) begin
            n_err++;
            $display("FAIL fl_pre got v%b p%0d r%b exp 1 1 0",
                     bus.out_valid, bus.lut_ppc, bus.in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, busy, bus.lut_ppc, bus.in_ready}
            !== {2'b00, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL fl_idle got v%b b%b p%0d r%b exp 0 0 0 1",
                     bus.out_valid, busy, bus.lut_ppc, bus.in_ready);
        end
        @(posedge clk); #1;
        start(32'h0BADF00D, 8'd64, 8'h00);
        @(negedge clk);
        n_vec++;
        if ({bus.out_first, bus.lut_ppc, bus.out_sub, bus.out_insn}
            !== {1'b1, 3'd0, 16'h2101, 32'h0BADF00D}) begin
            n_err++;
            $display("FAIL fl_restart got f%b p%0d s%h i%h",
                     bus.out_first, bus.lut_ppc, bus.out_sub, bus.out_insn);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL fl_done got %b exp 0", bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overrun;
        bus.out_ready = 1'b1;
        start(32'h99990000, 8'd99, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_vec++;
            if ({bus.out_valid, bus.out_first, bus.out_last, bus.lut_ppc,
                 bus.out_sub, err_overrun}
                !== {1'b1, k == 0, k == 7, 3'(k), 16'(32'h4200 + k), 1'b0}) begin
                n_err++;
                $display("FAIL ov_emit%0d got v%b f%b l%b p%0d s%h e%b", k,
                         bus.out_valid, bus.out_first, bus.out_last,
                         bus.lut_ppc, bus.out_sub, err_overrun);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({bus.out_valid, err_overrun} !== 2'b01) begin
            n_err++;
            $display("FAIL ov_flag got v%b e%b exp 01", bus.out_valid, err_overrun);
        end
        @(posedge clk); #1;
        start(32'h0, 8'd5, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (err_overrun !== 1'b1) begin
            n_err++; $display("FAIL ov_sticky got %b exp 1", err_overrun);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (err_overrun !== 1'b0) begin
            n_err++; $display("FAIL ov_clear got %b exp 0", err_overrun);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_rst_perf;
        bus.out_ready = 1'b1;
        start(32'h55556666, 8'd64, 8'h12);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.out_valid, bus.out_first, bus.out_last, busy, err_overrun,
             bus.in_ready} !== 6'b000001) begin
            n_err++;
            $display("FAIL rm_flags got v%b f%b l%b b%b e%b r%b",
                     bus.out_valid, bus.out_first, bus.out_last, busy,
                     err_overrun, bus.in_ready);
        end
        n_vec++;
        if ({bus.lut_index, bus.lut_ppc, bus.lut_key, bus.out_insn,
             perf_insn_cnt, perf_emit_cnt} !== 115'd0) begin
            n_err++;
            $display("FAIL rm_regs got x%h p%0d k%h i%h c%0d/%0d",
                     bus.lut_index, bus.lut_ppc, bus.lut_key, bus.out_insn,
                     perf_insn_cnt, perf_emit_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start(32'(i), 8'd5, 8'(i));
            @(negedge clk);
            n_vec++;
            if ({bus.out_valid, bus.out_first, bus.out_last, bus.out_insn}
                !== {3'b111, 32'(i)}) begin
                n_err++;
                $display("FAIL rm_pt%0d got v%b f%b l%b i%h", i, bus.out_valid,
                         bus.out_first, bus.out_last, bus.out_insn);
            end
            repeat (2) @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_vec++;
        if ({perf_insn_cnt, perf_emit_cnt} !== {32'(PERF_EXP), 32'(PERF_EXP)}) begin
            n_err++;
            $display("FAIL rm_perf got %0d/%0d exp %0d/%0d", perf_insn_cnt,
                     perf_emit_cnt, PERF_EXP, PERF_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_seq3();
        test_passthrough();
        test_stall();
        test_flush();
        test_overrun();
        test_rst_perf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
